// File: rtl/i2s_rx_tdm_pkg.sv
// Shared types for the I2S/TDM receive channel: FSM states, framing modes and
// the output buffer entry layout.
package i2s_rx_tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFSET,
    ST_SLOT,
    ST_WAIT
  } rx_state_e;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_TDM = 1'b1;

  // Entries are sized for the largest legal configuration (16 slots, 32-bit words).
  localparam int SLOT_IDX_W = 4;
  localparam int MAX_DATA_W = 32;

  typedef struct packed {
    logic [SLOT_IDX_W-1:0] slot;
    logic [MAX_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/i2s_rx_tdm_fifo.sv
// Generic synchronous FIFO with synchronous flush; a write into a full FIFO is
// accepted only when a read happens in the same cycle.
module i2s_rx_tdm_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_wr, w_rd;

  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_rd    = rd_i & ~empty_o;
  assign w_wr    = wr_i & (~full_o | w_rd);
  assign rdata_o = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= wdata_i;
  end

endmodule

// File: rtl/i2s_rx_tdm_channel.sv
// Serial receive channel: detects I2S/TDM frame starts, deserialises slot words
// and queues enabled slots into an output FIFO.
module i2s_rx_tdm_channel
  import i2s_rx_tdm_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sd_i,
  input  logic                         ws_i,
  input  logic                         cfg_en_i,
  input  logic                         cfg_mode_i,
  input  logic [3:0]                   cfg_offset_i,
  input  logic [4:0]                   cfg_wlen_i,
  input  logic [4:0]                   cfg_slot_w_i,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_nslots_i,
  input  logic [NUM_SLOTS-1:0]         cfg_slot_mask_i,
  input  logic                         cfg_lsb_first_i,
  output logic [DATA_W-1:0]            data_o,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         ovf_o,
  output logic                         frame_err_o
);
  localparam int SW = $clog2(NUM_SLOTS);

  rx_state_e         r_state, w_state_nxt;
  logic              r_ws_q;
  logic [4:0]        r_bit_cnt, w_bit_nxt, w_bit;
  logic [SW-1:0]     r_slot_cnt, w_slot_nxt, w_slot, w_start_slot, w_nslots;
  logic [3:0]        r_off_cnt, w_off_nxt;
  logic [DATA_W-1:0] r_shreg, w_sh_nxt, w_base;
  logic              w_rise, w_fall, w_start, w_err, w_cap, w_push, w_in_frame;
  logic              r_push_vld, r_ovf, r_ferr;
  rx_entry_t         r_push_entry, w_rentry;
  logic              w_full, w_empty, w_pop, w_ovf, w_unused;

  assign w_rise     = ws_i & ~r_ws_q;
  assign w_fall     = ~ws_i & r_ws_q;
  assign w_nslots   = (cfg_mode_i == MODE_I2S) ? SW'(1) : cfg_nslots_i;
  assign w_in_frame = (r_state == ST_OFFSET) || (r_state == ST_SLOT);

  // I2S: falling ws starts the frame at slot 0, rising ws re-aligns slot 1.
  always_comb begin
    w_start      = 1'b0;
    w_start_slot = '0;
    w_err        = 1'b0;
    if (cfg_mode_i == MODE_TDM) begin
      w_start = w_rise;
      w_err   = w_rise & w_in_frame;
    end else if (w_fall) begin
      w_start = 1'b1;
      w_err   = w_in_frame;
    end else if (w_rise && r_state != ST_IDLE) begin
      w_start      = 1'b1;
      w_start_slot = SW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_slot_nxt  = r_slot_cnt;
    w_off_nxt   = r_off_cnt;
    w_sh_nxt    = r_shreg;
    w_base      = '0;
    w_cap       = 1'b0;
    w_bit       = r_bit_cnt;
    w_slot      = r_slot_cnt;
    w_push      = 1'b0;
    if (!cfg_en_i) begin
      w_state_nxt = ST_IDLE;
      w_bit_nxt   = '0;
      w_slot_nxt  = '0;
      w_off_nxt   = '0;
      w_sh_nxt    = '0;
    end else begin
      if (w_start) begin
        w_bit_nxt  = '0;
        w_slot_nxt = w_start_slot;
        w_sh_nxt   = '0;
        // Zero offset: the detect cycle itself carries bit 0.
        if (cfg_offset_i == 4'd0) begin
          w_cap  = 1'b1;
          w_bit  = '0;
          w_slot = w_start_slot;
        end else if (cfg_offset_i == 4'd1) begin
          w_state_nxt = ST_SLOT;
        end else begin
          w_state_nxt = ST_OFFSET;
          w_off_nxt   = cfg_offset_i - 4'd1;
        end
      end else if (r_state == ST_OFFSET) begin
        if (r_off_cnt <= 4'd1) w_state_nxt = ST_SLOT;
        else                   w_off_nxt   = r_off_cnt - 4'd1;
      end else if (r_state == ST_SLOT) begin
        w_cap = 1'b1;
      end

      if (w_cap) begin
        w_base   = (w_bit == 5'd0) ? '0 : r_shreg;
        w_sh_nxt = w_base;
        if (w_bit <= cfg_wlen_i) begin
          if (cfg_lsb_first_i) begin
            for (int i = 0; i < DATA_W; i++)
              if (i == int'(w_bit)) w_sh_nxt[i] = sd_i;
          end else begin
            w_sh_nxt = {w_base[DATA_W-2:0], sd_i};
          end
        end
        w_push = (w_bit == cfg_wlen_i) && cfg_slot_mask_i[w_slot];
        if (w_bit == cfg_slot_w_i) begin
          w_bit_nxt = '0;
          if (w_slot == w_nslots) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_SLOT;
            w_slot_nxt  = w_slot + SW'(1);
          end
        end else begin
          w_state_nxt = ST_SLOT;
          w_bit_nxt   = w_bit + 5'd1;
          w_slot_nxt  = w_slot;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ws_q       <= 1'b0;
      r_bit_cnt    <= '0;
      r_slot_cnt   <= '0;
      r_off_cnt    <= '0;
      r_shreg      <= '0;
      r_push_vld   <= 1'b0;
      r_push_entry <= '0;
      r_ovf        <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_ws_q            <= ws_i;
      r_bit_cnt         <= w_bit_nxt;
      r_slot_cnt        <= w_slot_nxt;
      r_off_cnt         <= w_off_nxt;
      r_shreg           <= w_sh_nxt;
      r_push_vld        <= cfg_en_i & w_push;
      r_push_entry.slot <= SLOT_IDX_W'(w_slot);
      r_push_entry.data <= MAX_DATA_W'(w_sh_nxt);
      r_ovf             <= cfg_en_i & w_ovf;
      r_ferr            <= cfg_en_i & w_start & w_err;
    end
  end

  assign w_pop = ~w_empty & ready_i;
  assign w_ovf = r_push_vld & w_full & ~w_pop;

  i2s_rx_tdm_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (~cfg_en_i),
    .wr_i    (r_push_vld),
    .wdata_i (r_push_entry),
    .rd_i    (w_pop),
    .rdata_o (w_rentry),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign valid_o     = ~w_empty;
  assign data_o      = w_empty ? '0 : w_rentry.data[DATA_W-1:0];
  assign slot_o      = w_empty ? '0 : w_rentry.slot[SW-1:0];
  assign ovf_o       = r_ovf;
  assign frame_err_o = r_ferr;
  assign w_unused    = ^w_rentry;

endmodule

// File: doc/i2s_rx_tdm_channel.md
# i2s_rx_tdm_channel

Parametrised receive channel that deserialises one serial data line carrying up to NUM_SLOTS time-multiplexed words per frame, in I2S (2-slot, WS-level) or TDM (WS-pulse) framing. It is the generalised successor of the 2-channel I2S slave receiver, adding configurable slot count, slot width, per-slot enable mask, frame-sync offset and an internal output buffer. It sits between the pad-side serial inputs and the uDMA RX FIFO handshake.

## Interface
Parameters:
- NUM_SLOTS, 8: maximum slots per frame, 2..16.
- DATA_W, 32: maximum word length and width of data_o.
- DEPTH, 4: output buffer entries, power of 2, at least 2.

Ports:
- clk_i  in  1  serial bit clock. Every register samples on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- sd_i  in  1  serial data.
- ws_i  in  1  word select / frame sync.
- cfg_en_i  in  1  channel enable.
- cfg_mode_i  in  1  0 = I2S, 1 = TDM.
- cfg_offset_i  in  4  bit clocks between the frame-start detect and the first data bit (0..15).
- cfg_wlen_i  in  5  word length minus 1.
- cfg_slot_w_i  in  5  slot width minus 1. Must be at least cfg_wlen_i.
- cfg_nslots_i  in  log2(NUM_SLOTS)  active slots minus 1. Forced to 1 in I2S mode.
- cfg_slot_mask_i  in  NUM_SLOTS  per-slot capture enable.
- cfg_lsb_first_i  in  1  bit order.
- data_o  out  DATA_W  received word, right-aligned, zero-extended.
- slot_o  out  log2(NUM_SLOTS)  slot index of data_o.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  consumer accepts.
- ovf_o  out  1  one-cycle pulse: enabled word dropped because the buffer is full.
- frame_err_o  out  1  one-cycle pulse: frame start arrived before the frame completed.

## Operation
- Frame start (fs):
  - ws_q registers ws_i.
  - TDM mode: fs = ws_i & !ws_q.
  - I2S mode: fs = !ws_i & ws_q. A ws rising edge restarts slot 1 without raising an error.
- State machine: IDLE, OFFSET, SLOT, WAIT.
  - IDLE: waits for fs while cfg_en_i is high.
  - On fs, go to OFFSET if cfg_offset_i > 0, otherwise go directly to SLOT with the current bit as bit 0.
  - OFFSET: counts cfg_offset_i clocks, then goes to SLOT.
  - SLOT: bit_cnt runs 0..cfg_slot_w_i. Bits 0..cfg_wlen_i are captured and the rest are ignored.
  - At bit_cnt == cfg_slot_w_i, slot_cnt increments. Go to WAIT after slot cfg_nslots_i, otherwise stay in SLOT at bit_cnt 0.
  - WAIT: idles until fs, then behaves as IDLE on fs.
- Capture:
  - MSB-first: shreg = {shreg[DATA_W-2:0], sd_i}.
  - LSB-first: shreg[bit_cnt] = sd_i.
  - The shift register clears at each slot start.
- Push: on the cycle that samples bit cfg_wlen_i, if cfg_slot_mask_i[slot_cnt] is set, write {slot_cnt, word} to the buffer. If the buffer is full, drop the word and pulse ovf_o.
- Early fs:
  - In OFFSET or SLOT in TDM mode, or on the I2S falling edge before slot 1 completes: pulse frame_err_o.
  - Discard the partial word and restart from the fs handling with slot_cnt = 0.
- Buffer: FIFO of depth DEPTH. valid_o = !empty; data_o/slot_o come from the head.
  - Pop on valid_o & ready_i.
  - Push and pop in the same cycle when full is accepted, and the count is unchanged.
- cfg_en_i low: state goes to IDLE, counters clear, buffer is flushed, valid_o goes low on the next edge.
- Configuration changes are legal only while cfg_en_i is low.

## Timing
- Reset values: every output is 0, state IDLE, buffer empty, ws_q 0.
- Latency: valid_o rises on the edge after the push edge. The last data bit is sampled at edge N and valid_o is high from N+1.
- Slot period = cfg_slot_w_i + 1 clocks. Frame length = offset + (nslots + 1) × slot period.
- ovf_o and frame_err_o are registered, single-cycle, and may coincide.
- The reset takes priority over cfg_en_i and fs. A reset mid-frame loses the partial word and all buffered entries.

## Structure
- Package i2s_rx_tdm_pkg holds:
  - the state enum (IDLE/OFFSET/SLOT/WAIT);
  - the mode constants MODE_I2S = 0 and MODE_TDM = 1;
  - the buffer entry struct {slot, data}.
- Sub-module i2s_rx_tdm_fifo: generic synchronous FIFO with full/empty, DEPTH and width parameters, and a synchronous flush.

## Test plan
- TDM, 8 slots, wlen = 15, slot_w = 31, offset 1, mask 0xFF, MSB-first; send slot k = 0xA500 + k → 8 outputs in slot order, data 0x0000A50k.
- I2S mode, wlen = 23, slot_w = 31, LSB-first; L = 0x123456, R = 0xABCDEF → slot 0 = 0x00123456, slot 1 = 0x00ABCDEF.
- TDM, mask 0x05, 4 slots → only slots 0 and 2 are output; slots 1 and 3 produce no valid_o.
- ready_i held low for 6 words with DEPTH 4 → 4 stored, ovf_o pulses twice, the first 4 words drain intact.
- fs reasserted in the middle of slot 2 of a 4-slot frame → frame_err_o pulses once, the next word is tagged slot 0 with correct data.
- cfg_en_i dropped with 3 buffered words, then rst_i mid-frame → valid_o is 0 on the next edge, and capture resumes correctly from the next fs after re-enable.
